ula_timing: RTL and testbench
=============================

# ula_timing

Parametrised raster timing generator for the Spectrum video path. It produces the horizontal and vertical counters, blanking, sync, border and flash signals, the frame interrupt, and a new programmable line interrupt. It supports Pentagon, 48K and 128K profiles, selectable at runtime, plus a wide-border option. It sits between the pixel clock enables and the fetch, shift and mixer logic, replacing the hard-coded counters in the video controller.

## Interface
Parameters:
- HC_W, 9: horizontal counter width.
- VC_W, 9: vertical counter width.
- INT_LEN, 64: frame INT low time, in pixel-clock enables.
- FLASH_W, 5: frame counter width. Its MSB is the flash phase.

Ports:
- clk_sys  in  1  system clock. One clock domain.
- reset  in  1  synchronous, active-high reset.
- ce_pix  in  1  pixel clock enable (7 MHz). All state advances only on ce_pix.
- profile  in  2  0 = Pentagon, 1 = 48K, 2 = 128K, 3 = reserved (treated as 48K).
- wide  in  1  wide-border blanking.
- line_irq_ena  in  1  enables the line interrupt.
- line_irq_line  in  VC_W  line on which the line interrupt fires.
- line_irq_ack  in  1  one-clk pulse that clears line_irq.
- hc  out  HC_W  horizontal count.
- vc  out  VC_W  vertical count.
- hblank, vblank, hsync, vsync  out  1  each.
- border  out  1  high when vc[8], vc[7]&vc[6], or hc[8] is set.
- int_n  out  1  frame interrupt, active low.
- line_irq  out  1  sticky line-interrupt flag.
- flash  out  1  MSB of the frame counter.
- frame_start  out  1  one-clk pulse when the counters wrap to (0,0).

## Operation
- Profile constants, as (last hc, last vc, INT point):
  - Pentagon: 447, 319, INT at vc 239 / hc 326.
  - 48K: 447, 311, INT at vc 248 / hc 4.
  - 128K: 455, 310, INT at vc 248 / hc 8.
- Counters:
  - hc increments per ce_pix and wraps at last hc.
  - vc increments on the hc wrap and wraps at last vc.
  - The frame counter increments on the vc wrap.
- The active profile is latched only at frame wrap. A profile change mid-frame takes effect from the next (0,0).
- Horizontal events (set at hc equality): hblank on / hsync on / hsync off / hblank off.
  - Pentagon: 312 / 338 / 370 / 420.
  - 48K: 300 / 336 / 368 / 428.
  - 128K: 312 / 340 / 372 / 424.
- Vertical events are evaluated only on the ce_pix where hsync rises:
  - 48K/128K: vblank 236..263, vsync 240..243.
  - Pentagon: vblank 236..271, vsync 248..255.
- Wide mode overrides the standard events:
  - hblank = (312 ≤ hc < last hc − 32).
  - vblank = (193 ≤ vc < last vc − 3), evaluated at hsync rise.
- Frame INT:
  - int_n falls on the ce_pix where (vc,hc) equals the INT point.
  - It stays low for exactly INT_LEN ce_pix, then rises.
  - A new match while low does not extend the low time.
- Line interrupt:
  - line_irq is set on the ce_pix where hc == 0, vc == line_irq_line, and line_irq_ena = 1.
  - It is cleared by line_irq_ack.
  - If set and ack coincide, set wins.
  - A line_irq_line value above last vc never fires.
  - Clearing line_irq_ena does not clear a pending flag.

## Timing
- All outputs are registered and update in the clk_sys cycle after the sampled ce_pix. Latency from counter value to event output is 0 ce.
- frame_start is high for exactly one clk_sys, in the cycle where hc and vc become 0.
- Without ce_pix, every output holds.
- Reset values:
  - hc = 0, vc = 0, frame counter = 0, profile latch = input value.
  - hblank = 1, vblank = 1, hsync = 0, vsync = 0.
  - int_n = 1, line_irq = 0, frame_start = 0.
- Reset mid-INT or mid-frame aborts immediately; there is no partial pulse afterwards.
- Reset has priority over ce_pix and line_irq_ack.

## Structure
- ula_timing_pkg holds:
  - the profile_t enum;
  - a struct ula_prof_t with fields h_last, v_last, hb_on, hs_on, hs_off, hb_off, vb_on, vs_on, vs_off, vb_off, int_v, int_h;
  - a function returning ula_prof_t for a given profile_t.
- Sub-module ula_timing_irq contains the INT_LEN counter and the line_irq flag logic.
- The main module contains the counters, the profile latch and the blank/sync registers.

## Test plan
- Reset, then 48K for 2 frames:
  - line length 448 and frame length 312 lines;
  - int_n low exactly 64 ce starting at vc 248, hc 4;
  - frame_start once per 139776 ce.
- Switch profile to 128K at vc 100:
  - the current frame finishes with 312 lines;
  - the next frame has 311 lines of 456;
  - INT falls at hc 8.
- Pentagon:
  - hsync high at hc 338..369, hblank high at hc 312..419;
  - vsync high on lines 248..255;
  - INT at vc 239, hc 326.
- Wide = 1 on 48K: hblank high for hc 312..414 and vblank high for vc 193..307.
- line_irq_line = 50, ena = 1:
  - the flag sets at vc 50, hc 0;
  - an ack in the same cycle as the set leaves the flag at 1;
  - a later ack clears it;
  - line_irq_line = 400 never fires.
- Reset asserted while int_n is low: int_n = 1 in the next cycle and all counters return to 0.

Source files
------------

// File: rtl/ula_timing_pkg.sv
// Shared types and per-machine raster constants for the ULA timing generator.
// All raster positions are 9-bit values.
package ula_timing_pkg;

  localparam int PROF_W = 9;

  typedef enum logic [1:0] {
    PROF_PENTAGON = 2'd0,
    PROF_48K      = 2'd1,
    PROF_128K     = 2'd2,
    PROF_RSVD     = 2'd3
  } profile_t;

  // The *_off fields are the first position where the signal is low again.
  typedef struct packed {
    logic [PROF_W-1:0] h_last;
    logic [PROF_W-1:0] v_last;
    logic [PROF_W-1:0] hb_on;
    logic [PROF_W-1:0] hs_on;
    logic [PROF_W-1:0] hs_off;
    logic [PROF_W-1:0] hb_off;
    logic [PROF_W-1:0] vb_on;
    logic [PROF_W-1:0] vs_on;
    logic [PROF_W-1:0] vs_off;
    logic [PROF_W-1:0] vb_off;
    logic [PROF_W-1:0] int_v;
    logic [PROF_W-1:0] int_h;
  } ula_prof_t;

  localparam logic [PROF_W-1:0] WIDE_HB_ON     = 9'd312;
  localparam logic [PROF_W-1:0] WIDE_H_MARGIN  = 9'd32;
  localparam logic [PROF_W-1:0] WIDE_VB_ON     = 9'd193;
  localparam logic [PROF_W-1:0] WIDE_V_MARGIN  = 9'd3;

  // The reserved encoding behaves exactly like the 48K machine.
  function automatic ula_prof_t prof_lookup(input profile_t p);
    ula_prof_t r;
    case (p)
      PROF_PENTAGON: r = '{h_last: 9'd447, v_last: 9'd319,
                           hb_on: 9'd312, hs_on: 9'd338, hs_off: 9'd370, hb_off: 9'd420,
                           vb_on: 9'd236, vs_on: 9'd248, vs_off: 9'd256, vb_off: 9'd272,
                           int_v: 9'd239, int_h: 9'd326};
      PROF_128K:     r = '{h_last: 9'd455, v_last: 9'd310,
                           hb_on: 9'd312, hs_on: 9'd340, hs_off: 9'd372, hb_off: 9'd424,
                           vb_on: 9'd236, vs_on: 9'd240, vs_off: 9'd244, vb_off: 9'd264,
                           int_v: 9'd248, int_h: 9'd8};
      default:       r = '{h_last: 9'd447, v_last: 9'd311,
                           hb_on: 9'd300, hs_on: 9'd336, hs_off: 9'd368, hb_off: 9'd428,
                           vb_on: 9'd236, vs_on: 9'd240, vs_off: 9'd244, vb_off: 9'd264,
                           int_v: 9'd248, int_h: 9'd4};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ula_timing_irq.sv
// Frame INT pulse stretcher and sticky line-interrupt flag.
// Both advance on the same pixel enable as the raster counters.
module ula_timing_irq #(
  parameter int INT_LEN = 64
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic ce_pix,
  input  logic int_hit,
  input  logic line_hit,
  input  logic line_irq_ack,
  output logic int_n,
  output logic line_irq
);
  import ula_timing_pkg::*;

  localparam int CNT_W = $clog2(INT_LEN + 1);

  logic [CNT_W-1:0] int_cnt;

  // int_cnt holds the remaining low enables after the current one; a match
  // while already low is ignored so the pulse is never stretched.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      int_n    <= 1'b1;
      int_cnt  <= '0;
      line_irq <= 1'b0;
    end else begin
      if (ce_pix) begin
        if (!int_n) begin
          if (int_cnt == '0) int_n <= 1'b1;
          else               int_cnt <= int_cnt - CNT_W'(1);
        end else if (int_hit) begin
          int_n   <= 1'b0;
          int_cnt <= CNT_W'(INT_LEN - 1);
        end
      end
      if (ce_pix && line_hit) line_irq <= 1'b1;
      else if (line_irq_ack)  line_irq <= 1'b0;
    end
  end

endmodule

// File: rtl/ula_timing.sv
// Raster timing generator: counters, profile latch, blank/sync/border registers.
// Event outputs are computed from the next counter values so they line up with hc/vc.
module ula_timing #(
  parameter int HC_W    = 9,
  parameter int VC_W    = 9,
  parameter int INT_LEN = 64,
  parameter int FLASH_W = 5
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            ce_pix,
  input  logic [1:0]      profile,
  input  logic            wide,
  input  logic            line_irq_ena,
  input  logic [VC_W-1:0] line_irq_line,
  input  logic            line_irq_ack,
  output logic [HC_W-1:0] hc,
  output logic [VC_W-1:0] vc,
  output logic            hblank,
  output logic            vblank,
  output logic            hsync,
  output logic            vsync,
  output logic            border,
  output logic            int_n,
  output logic            line_irq,
  output logic            flash,
  output logic            frame_start
);
  import ula_timing_pkg::*;

  profile_t           prof_sel;
  ula_prof_t          prof;
  logic [FLASH_W-1:0] frame_cnt;
  logic [HC_W-1:0]    hc_nx;
  logic [VC_W-1:0]    vc_nx;
  logic               h_wrap;
  logic               v_wrap;
  logic               frame_wrap;
  logic               hs_rise;
  logic               int_hit;
  logic               line_hit;
  logic               border_nx;
  logic               wide_hb;
  logic               wide_vb;
  logic               std_vb;
  logic               std_vs;

  always_comb prof = prof_lookup(prof_sel);

  always_comb begin
    h_wrap     = (hc == HC_W'(prof.h_last));
    v_wrap     = (vc == VC_W'(prof.v_last));
    hc_nx      = h_wrap ? '0 : hc + HC_W'(1);
    vc_nx      = vc;
    if (h_wrap) vc_nx = v_wrap ? '0 : vc + VC_W'(1);
    frame_wrap = h_wrap && v_wrap;
    hs_rise    = (hc_nx == HC_W'(prof.hs_on));
    int_hit    = (vc_nx == VC_W'(prof.int_v)) && (hc_nx == HC_W'(prof.int_h));
    line_hit   = line_irq_ena && (hc_nx == '0) && (vc_nx == line_irq_line);
    border_nx  = vc_nx[8] | (vc_nx[7] & vc_nx[6]) | hc_nx[8];
    wide_hb    = (hc_nx >= HC_W'(WIDE_HB_ON)) &&
                 (hc_nx <  HC_W'(prof.h_last - WIDE_H_MARGIN));
    wide_vb    = (vc_nx >= VC_W'(WIDE_VB_ON)) &&
                 (vc_nx <  VC_W'(prof.v_last - WIDE_V_MARGIN));
    std_vb     = (vc_nx >= VC_W'(prof.vb_on)) && (vc_nx < VC_W'(prof.vb_off));
    std_vs     = (vc_nx >= VC_W'(prof.vs_on)) && (vc_nx < VC_W'(prof.vs_off));
  end

  // A new profile is only picked up on the wrap to (0,0) so frames never mix timings.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hc          <= '0;
      vc          <= '0;
      frame_cnt   <= '0;
      prof_sel    <= profile_t'(profile);
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      border      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (ce_pix) begin
        hc          <= hc_nx;
        vc          <= vc_nx;
        border      <= border_nx;
        frame_start <= frame_wrap;
        if (frame_wrap) begin
          frame_cnt <= frame_cnt + FLASH_W'(1);
          prof_sel  <= profile_t'(profile);
        end
        if (wide)                               hblank <= wide_hb;
        else if (hc_nx == HC_W'(prof.hb_on))    hblank <= 1'b1;
        else if (hc_nx == HC_W'(prof.hb_off))   hblank <= 1'b0;
        if (hc_nx == HC_W'(prof.hs_on))         hsync  <= 1'b1;
        else if (hc_nx == HC_W'(prof.hs_off))   hsync  <= 1'b0;
        if (hs_rise) begin
          vblank <= wide ? wide_vb : std_vb;
          vsync  <= std_vs;
        end
      end
    end
  end

  assign flash = frame_cnt[FLASH_W-1];

  ula_timing_irq #(
    .INT_LEN(INT_LEN)
  ) u_irq (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ce_pix      (ce_pix),
    .int_hit     (int_hit),
    .line_hit    (line_hit),
    .line_irq_ack(line_irq_ack),
    .int_n       (int_n),
    .line_irq    (line_irq)
  );

endmodule

// File: tb/tb_ula_timing.sv
// Randomised bench for ula_timing: a position-based raster model is compared
// against the DUT every cycle, with literal checks on key frame events.
module tb_ula_timing;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       ce_pix;
  logic [1:0] profile;
  logic       wide;
  logic       line_irq_ena;
  logic [8:0] line_irq_line;
  logic       line_irq_ack;
  logic [8:0] hc;
  logic [8:0] vc;
  logic       hblank, vblank, hsync, vsync, border, int_n, line_irq, flash, frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_sys = ~clk_sys;

  ula_timing dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ce_pix       (ce_pix),
    .profile      (profile),
    .wide         (wide),
    .line_irq_ena (line_irq_ena),
    .line_irq_line(line_irq_line),
    .line_irq_ack (line_irq_ack),
    .hc           (hc),
    .vc           (vc),
    .hblank       (hblank),
    .vblank       (vblank),
    .hsync        (hsync),
    .vsync        (vsync),
    .border       (border),
    .int_n        (int_n),
    .line_irq     (line_irq),
    .flash        (flash),
    .frame_start  (frame_start)
  );

  // Machine tables, index 0 = Pentagon, 1 = 48K, 2 = 128K; vertical ranges inclusive.
  int H_LAST[3]   = '{447, 447, 455};
  int V_LAST[3]   = '{319, 311, 310};
  int HB_ON[3]    = '{312, 300, 312};
  int HS_ON[3]    = '{338, 336, 340};
  int HS_OFF[3]   = '{370, 368, 372};
  int HB_OFF[3]   = '{420, 428, 424};
  int VB_FIRST[3] = '{236, 236, 236};
  int VB_LAST[3]  = '{271, 263, 263};
  int VS_FIRST[3] = '{248, 240, 240};
  int VS_LAST[3]  = '{255, 243, 243};
  int INT_V[3]    = '{239, 248, 248};
  int INT_H[3]    = '{326, 4, 8};

  int INT_V_LIT[3] = '{248, 248, 239};
  int INT_H_LIT[3] = '{4, 8, 326};
  int FRAME_LIT[2] = '{139776, 141816};

  int m_hc, m_vc, m_frame, m_prof, m_int_left, ce_total, p;
  bit m_hblank, m_vblank, m_hsync, m_vsync, m_int_n, m_irq, m_fs, m_in_reset, irq_set;
  bit model_ready = 1'b0;

  bit gap_on, rand_wide, rand_ack;

  function automatic int prof_idx(input logic [1:0] sel);
    return (sel == 2'd3) ? 1 : int'(sel);
  endfunction

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      if (n_fail >= 20) begin
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
      end
    end
  endtask

  // Reference raster: position arithmetic plus a few sticky flags.
  always @(posedge clk_sys) begin
    m_in_reset = reset;
    if (reset) begin
      m_hc = 0; m_vc = 0; m_frame = 0; m_prof = prof_idx(profile);
      m_hblank = 1; m_vblank = 1; m_hsync = 0; m_vsync = 0;
      m_int_n = 1; m_int_left = 0; m_irq = 0; m_fs = 0; ce_total = 0;
      model_ready = 1'b1;
    end else begin
      m_fs = 0;
      irq_set = 0;
      if (ce_pix) begin
        ce_total++;
        if (m_hc == H_LAST[m_prof]) begin
          m_hc = 0;
          if (m_vc == V_LAST[m_prof]) begin
            m_vc = 0; m_frame = (m_frame + 1) % 32; m_fs = 1; m_prof = prof_idx(profile);
          end else m_vc++;
        end else m_hc++;
        p = m_prof;
        if (wide) m_hblank = (m_hc >= 312) && (m_hc < H_LAST[p] - 32);
        else if (m_hc == HB_ON[p])  m_hblank = 1;
        else if (m_hc == HB_OFF[p]) m_hblank = 0;
        m_hsync = (m_hc >= HS_ON[p]) && (m_hc < HS_OFF[p]);
        if (m_hc == HS_ON[p]) begin
          m_vblank = wide ? ((m_vc >= 193) && (m_vc < V_LAST[p] - 3))
                          : ((m_vc >= VB_FIRST[p]) && (m_vc <= VB_LAST[p]));
          m_vsync  = (m_vc >= VS_FIRST[p]) && (m_vc <= VS_LAST[p]);
        end
        if (!m_int_n) begin
          m_int_left--;
          if (m_int_left == 0) m_int_n = 1;
        end else if (m_vc == INT_V[p] && m_hc == INT_H[p]) begin
          m_int_n = 0; m_int_left = 64;
        end
        if (line_irq_ena && m_hc == 0 && m_vc == int'(line_irq_line)) irq_set = 1;
      end
      if (irq_set) m_irq = 1;
      else if (line_irq_ack) m_irq = 0;
    end
  end

  bit prev_int_n = 1'b1, prev_irq = 1'b0, int_track = 1'b0;
  int int_fall_ce, last_fs_ce, fs_seen = 0;
  logic [26:0] act_v, exp_v;
  logic m_border, m_flash;

  always @(negedge clk_sys) begin
    if (model_ready) begin
      m_border = (m_vc >= 256) || ((m_vc % 256) >= 192) || (m_hc >= 256);
      m_flash  = (m_frame >= 16);
      act_v = {hc, vc, hblank, vblank, hsync, vsync, border, int_n, line_irq, flash, frame_start};
      exp_v = {9'(m_hc), 9'(m_vc), m_hblank, m_vblank, m_hsync, m_vsync, m_border,
               m_int_n, m_irq, m_flash, m_fs};
      check_output("cycle", int'(act_v), int'(exp_v));
      if (m_in_reset) begin
        int_track  = 0;
        last_fs_ce = 0;
      end else begin
        if (prev_int_n && !int_n) begin
          if (fs_seen < 3) begin
            check_output("int_fall_vc", int'(vc), INT_V_LIT[fs_seen]);
            check_output("int_fall_hc", int'(hc), INT_H_LIT[fs_seen]);
          end
          int_fall_ce = ce_total;
          int_track   = 1;
        end
        if (!prev_int_n && int_n && int_track) begin
          check_output("int_low_len", ce_total - int_fall_ce, 64);
          int_track = 0;
        end
        if (frame_start) begin
          if (fs_seen < 2) check_output("frame_len", ce_total - last_fs_ce, FRAME_LIT[fs_seen]);
          last_fs_ce = ce_total;
          fs_seen++;
        end
        if (!prev_irq && line_irq && fs_seen == 0) begin
          check_output("irq_set_vc", int'(vc), 50);
          check_output("irq_set_hc", int'(hc), 0);
        end
      end
      prev_int_n = int_n;
      prev_irq   = line_irq;
    end
  end

  task automatic apply_stimulus();
    ce_pix       = gap_on ? ($urandom_range(7) != 0) : 1'b1;
    line_irq_ack = rand_ack && ($urandom_range(1023) == 0);
    if (rand_wide && m_hc == 0) wide = ($urandom_range(1) == 1);
    if (rand_ack && m_hc == 200 && $urandom_range(15) == 0)
      line_irq_line = 9'(m_vc + int'($urandom_range(3, 1)));
    if (rand_ack && m_hc == 100 && $urandom_range(31) == 0)
      line_irq_ena = ~line_irq_ena;
  endtask

  task automatic drive_cycle();
    @(negedge clk_sys);
    apply_stimulus();
  endtask

  task automatic run_until(input int v, input int h);
    int n = 0;
    while (!(m_vc == v && m_hc == h)) begin
      if (n >= 200000) begin
        check_output("run_until_timeout", n, -1);
        break;
      end
      drive_cycle();
      n++;
    end
  endtask

  initial begin
    reset = 1'b1; profile = 2'd1; wide = 1'b0; line_irq_ena = 1'b1;
    line_irq_line = 9'd50; line_irq_ack = 1'b0; ce_pix = 1'b0;
    gap_on = 1'b1; rand_wide = 1'b0; rand_ack = 1'b0;
    repeat (3) @(negedge clk_sys);
    check_output("rst_hc", int'(hc), 0);
    check_output("rst_vc", int'(vc), 0);
    check_output("rst_hblank", int'(hblank), 1);
    check_output("rst_vblank", int'(vblank), 1);
    check_output("rst_hsync", int'(hsync), 0);
    check_output("rst_vsync", int'(vsync), 0);
    check_output("rst_int_n", int'(int_n), 1);
    check_output("rst_line_irq", int'(line_irq), 0);
    check_output("rst_frame_start", int'(frame_start), 0);
    reset = 1'b0;

    // 48K frame with pixel-enable gaps at the start.
    repeat (2000) drive_cycle();
    gap_on = 1'b0;
    run_until(49, 447);
    ce_pix = 1'b1;
    line_irq_ack = 1'b1;
    drive_cycle();
    check_output("irq_set_beats_ack", int'(line_irq), 1);
    run_until(60, 0);
    line_irq_ack = 1'b1;
    drive_cycle();
    check_output("irq_ack_clears", int'(line_irq), 0);
    line_irq_line = 9'd400;
    run_until(100, 0);
    profile = 2'd2;
    run_until(180, 0);
    rand_wide = 1'b1;

    // 128K frame, Pentagon requested mid-frame.
    run_until(0, 0);
    rand_wide = 1'b0;
    wide = 1'b0;
    run_until(100, 0);
    profile = 2'd0;
    run_until(270, 0);
    rand_wide = 1'b1;
    run_until(310, 0);
    check_output("irq_line_400_silent", int'(line_irq), 0);

    // Pentagon frame with random line interrupts, aborted by reset mid-INT.
    run_until(0, 0);
    rand_wide = 1'b0;
    wide = 1'b0;
    rand_ack = 1'b1;
    run_until(239, 326);
    repeat (10) drive_cycle();
    check_output("int_low_before_reset", int'(int_n), 0);
    reset = 1'b1;
    profile = 2'd3;
    drive_cycle();
    check_output("reset_int_n", int'(int_n), 1);
    check_output("reset_hc", int'(hc), 0);
    check_output("reset_vc", int'(vc), 0);
    check_output("reset_frame_start", int'(frame_start), 0);
    reset = 1'b0;
    gap_on = 1'b1;
    rand_wide = 1'b1;
    repeat (3000) drive_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
